// File: rtl/tr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// tr_fetch_pkg
// Shared definitions for the test-runner vector fetch block: the default
// SRAM geometry (matching the SRAM arbiter), the default output FIFO depth
// and the fetch controller state type.
// ---------------------------------------------------------------------------
package tr_fetch_pkg;

    localparam int unsigned TR_ADDR_WIDTH = 20;
    localparam int unsigned TR_DATA_WIDTH = 16;
    localparam int unsigned TR_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tr_state_e;

endpackage

// File: rtl/tr_fifo.sv
// ---------------------------------------------------------------------------
// tr_fifo
// Small synchronous FIFO buffering SRAM words for the vector driver.
// A push and a pop in the same cycle are both performed.
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   push, push_data      write side
//   pop, pop_data        read side; pop_data is the head (0 when empty)
//   full, empty, count   registered occupancy status
// ---------------------------------------------------------------------------
module tr_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_W:0]        count
);

    localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        occ;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (PTR_W+1)'(1);
                2'b01:   occ <= occ - (PTR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_comb begin
        full     = (occ == OCC_FULL);
        empty    = (occ == '0);
        count    = occ;
        pop_data = empty ? '0 : mem[rd_ptr];
    end

    a_no_overflow:  assert property (@(posedge clock) disable iff (reset) !(push && full));
    a_no_underflow: assert property (@(posedge clock) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/tr_vector_fetch.sv
// ---------------------------------------------------------------------------
// tr_vector_fetch
// Avalon-MM read master on the test-runner side of the SRAM arbiter. On an
// accepted start it reads word_count consecutive words from base_addr,
// buffers them in tr_fifo and streams them to the vector driver.
// Arbiter stalls (tr_waitrequest) hold address and read stable.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   start, base_addr, word_count transfer request (honoured only when idle)
//   busy, done                   status; done is a one-cycle pulse
//   tr_*                         Avalon-MM master towards the arbiter
//   out_data/out_valid/out_ready word stream to the vector driver
// Optional build macro:
//   TR_FETCH_SUM_EN  adds output sum: modular sum of all words fetched since
//                    the last accepted start.
// ---------------------------------------------------------------------------
module tr_vector_fetch
    import tr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = TR_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = TR_DATA_WIDTH,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH  = 20,
    parameter int unsigned FIFO_DEPTH = TR_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] tr_address,
    output logic [BE_WIDTH-1:0]   tr_byteenable,
    output logic                  tr_read,
    input  logic [DATA_WIDTH-1:0] tr_readdata,
    output logic                  tr_write,
    output logic [DATA_WIDTH-1:0] tr_writedata,
    input  logic                  tr_waitrequest,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
`ifdef TR_FETCH_SUM_EN
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum
`else
    input  logic                  out_ready
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    tr_state_e             state;
    tr_state_e             state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  rem;
    logic                  accept;
    logic                  beat;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PTR_W:0]        fifo_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // tr_read depends only on registered state: a FIFO that is full at the
    // start of a cycle issues no read, even if a pop happens in that cycle.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        tr_read       = 1'b0;
        tr_address    = addr;
        tr_byteenable = '1;
        tr_write      = 1'b0;
        tr_writedata  = '0;
        out_valid     = !fifo_empty;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (word_count != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy    = 1'b1;
                tr_read = (rem != '0) && !fifo_full;
                if (tr_read && !tr_waitrequest && (rem == CNT_WIDTH'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (fifo_count == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        beat = tr_read && !tr_waitrequest;
        pop  = out_valid && out_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr <= '0;
            rem  <= '0;
        end else if (accept) begin
            addr <= base_addr;
            rem  <= word_count;
        end else if (beat) begin
            addr <= addr + ADDR_WIDTH'(1);
            rem  <= rem - CNT_WIDTH'(1);
        end
    end

`ifdef TR_FETCH_SUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            sum <= '0;
        end else if (accept) begin
            sum <= '0;
        end else if (beat) begin
            sum <= sum + tr_readdata;
        end
    end
`endif

    tr_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (beat),
        .push_data (tr_readdata),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_tr_vector_fetch.sv
// ---------------------------------------------------------------------------
// tb_tr_vector_fetch
// Directed bench for tr_vector_fetch with a transfer-level reference model
// (expected address/data queues plus a word-occupancy count) checked on
// every cycle, and literal expectations for each directed case.
// ---------------------------------------------------------------------------
module tb_tr_vector_fetch;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [19:0] word_count = '0;
    logic        busy;
    logic        done;
    logic [19:0] tr_address;
    logic [1:0]  tr_byteenable;
    logic        tr_read;
    logic [15:0] tr_readdata;
    logic        tr_write;
    logic [15:0] tr_writedata;
    logic        tr_waitrequest = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
`ifdef TR_FETCH_SUM_EN
    logic [15:0] sum;
    logic [15:0] m_sum = '0;
`endif

    int total = 0;
    int bad   = 0;

    bit mon_en = 1'b0;
    bit m_xfer = 1'b0;
    bit m_pend = 1'b0;
    int m_rem  = 0;
    int m_occ  = 0;
    logic [19:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [19:0] beat_log[$];
    logic [15:0] out_log[$];
    int done_cnt = 0;
    int done_at  = -1;
    int cyc_idx  = 0;
    int n_pre    = 0;

    always #5 clock = ~clock;

    tr_vector_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .tr_address     (tr_address),
        .tr_byteenable  (tr_byteenable),
        .tr_read        (tr_read),
        .tr_readdata    (tr_readdata),
        .tr_write       (tr_write),
        .tr_writedata   (tr_writedata),
        .tr_waitrequest (tr_waitrequest),
        .out_data       (out_data),
        .out_valid      (out_valid),
`ifdef TR_FETCH_SUM_EN
        .out_ready      (out_ready),
        .sum            (sum)
`else
        .out_ready      (out_ready)
`endif
    );

    // SRAM contents seen through the arbiter
    function automatic logic [15:0] exp_word(input logic [19:0] a);
        case (a)
            20'h00010: return 16'hA001;
            20'h00011: return 16'hA002;
            20'h00012: return 16'hA003;
            20'h00020: return 16'hFFFF;
            20'h00021: return 16'h0002;
            default:   return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    always_comb tr_readdata = exp_word(tr_address);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic monitor_step();
        bit   idle;
        bit   exp_read;
        bit   drained;
        logic [19:0] a;
        idle     = !m_xfer && !m_pend;
        exp_read = m_xfer && (m_rem != 0) && (m_occ < DEPTH);
        drained  = m_xfer && (m_rem == 0) && (m_occ == 0);

        chk("busy", 32'(busy), 32'(m_xfer));
        chk("done", 32'(done), 32'(m_pend));
        chk("tr_read", 32'(tr_read), 32'(exp_read));
        chk("out_valid", 32'(out_valid), 32'(m_occ != 0));
        chk("byteenable", 32'(tr_byteenable), 32'h3);
        chk("tr_write", 32'(tr_write), 32'h0);
        chk("writedata", 32'(tr_writedata), 32'h0);
`ifdef TR_FETCH_SUM_EN
        if (idle || m_pend) chk("sum", 32'(sum), 32'(m_sum));
`endif
        if (exp_read && tr_waitrequest && exp_addr_q.size() > 0)
            chk("addr_hold", 32'(tr_address), 32'(exp_addr_q[0]));

        if (tr_read && !tr_waitrequest) begin
            if (exp_addr_q.size() == 0) begin
                chk("extra_read", 32'(tr_read), 32'h0);
            end else begin
                a = exp_addr_q.pop_front();
                chk("rd_addr", 32'(tr_address), 32'(a));
                beat_log.push_back(tr_address);
                exp_data_q.push_back(exp_word(a));
                m_rem--;
                m_occ++;
`ifdef TR_FETCH_SUM_EN
                m_sum = m_sum + exp_word(a);
`endif
            end
        end

        if (out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
                chk("extra_pop", 32'(out_valid), 32'h0);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_data_q.pop_front()));
                out_log.push_back(out_data);
                if (m_occ > 0) m_occ--;
            end
        end

        if (done) begin
            done_cnt++;
            done_at = cyc_idx;
        end

        if (m_pend) begin
            m_pend = 1'b0;
        end else if (drained) begin
            m_xfer = 1'b0;
            m_pend = 1'b1;
        end

        if (idle && start) begin
`ifdef TR_FETCH_SUM_EN
            m_sum = '0;
`endif
            if (word_count != '0) begin
                m_xfer = 1'b1;
                m_rem  = int'(word_count);
                for (int unsigned i = 0; i < int'(word_count); i++)
                    exp_addr_q.push_back(20'(base_addr + i));
            end else begin
                m_pend = 1'b1;
            end
        end

        if (reset) begin
            m_xfer = 1'b0;
            m_pend = 1'b0;
            m_rem  = 0;
            m_occ  = 0;
            exp_addr_q.delete();
            exp_data_q.delete();
`ifdef TR_FETCH_SUM_EN
            m_sum = '0;
`endif
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) monitor_step();
    end

    // One transfer: out_ready low before cycle rdy_after, waitrequest high in
    // cycles st_lo..st_hi (cycle 1 is the first cycle after start is sampled),
    // and a stray start in cycle 2 that must be ignored.
    task automatic xfer(input logic [19:0] b, input logic [19:0] wc, input int rdy_after,
                        input int st_lo, input int st_hi);
        beat_log.delete();
        out_log.delete();
        done_cnt = 0;
        done_at  = -1;
        n_pre    = -1;
        base_addr      = b;
        word_count     = wc;
        start          = 1'b1;
        out_ready      = (rdy_after <= 0);
        tr_waitrequest = 1'b0;
        cyc_idx        = 0;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 300 && done_cnt == 0; k++) begin
            cyc_idx = k;
            if (k == rdy_after) n_pre = beat_log.size();
            out_ready      = (k >= rdy_after);
            tr_waitrequest = (k >= st_lo && k <= st_hi);
            start          = (k == 2);
            cyc();
        end
        start          = 1'b0;
        tr_waitrequest = 1'b0;
        out_ready      = 1'b1;
        chk("done_once", 32'(done_cnt), 32'd1);
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_tr_read", 32'(tr_read), 32'h0);
        chk("rst_address", 32'(tr_address), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;
        cyc();

        // basic read
        xfer(20'h00010, 20'd3, 0, 0, -1);
        chk("basic_n", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            chk("basic_w0", 32'(out_log[0]), 32'hA001);
            chk("basic_w1", 32'(out_log[1]), 32'hA002);
            chk("basic_w2", 32'(out_log[2]), 32'hA003);
        end
        if (beat_log.size() == 3) begin
            chk("basic_a0", 32'(beat_log[0]), 32'h00010);
            chk("basic_a2", 32'(beat_log[2]), 32'h00012);
        end

        // arbiter stall in cycles 2-6
        xfer(20'h00010, 20'd3, 0, 2, 6);
        chk("stall_n", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            chk("stall_w0", 32'(out_log[0]), 32'hA001);
            chk("stall_w2", 32'(out_log[2]), 32'hA003);
        end

        // backpressure: consumer stalls until cycle 10
        xfer(20'h00100, 20'd8, 10, 0, -1);
        chk("bp_reads_before_release", 32'(n_pre), 32'd4);
        chk("bp_n", 32'(out_log.size()), 32'd8);
        if (out_log.size() == 8) begin
            chk("bp_w0", 32'(out_log[0]), 32'h5B5A);
            chk("bp_w7", 32'(out_log[7]), 32'h5B5D);
        end

        // zero-length transfer
        xfer(20'h00050, 20'd0, 0, 0, -1);
        chk("zero_reads", 32'(beat_log.size()), 32'd0);
        chk("zero_done_cycle", 32'(done_at), 32'd1);

        // address wrap
        xfer(20'hFFFFF, 20'd2, 0, 0, -1);
        chk("wrap_n", 32'(beat_log.size()), 32'd2);
        if (beat_log.size() == 2) begin
            chk("wrap_a0", 32'(beat_log[0]), 32'hFFFFF);
            chk("wrap_a1", 32'(beat_log[1]), 32'h00000);
        end

        // reset in the middle of a 6-word transfer
        beat_log.delete();
        done_cnt   = 0;
        base_addr  = 20'h00030;
        word_count = 20'd6;
        out_ready  = 1'b1;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 50 && beat_log.size() < 2; k++) cyc();
        chk("mid_reads", 32'(beat_log.size()), 32'd2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_tr_read", 32'(tr_read), 32'h0);
        chk("mid_out_valid", 32'(out_valid), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 5; k++) cyc();
        chk("mid_no_done", 32'(done_cnt), 32'd0);
        xfer(20'h00040, 20'd1, 0, 0, -1);
        chk("after_rst_n", 32'(out_log.size()), 32'd1);
        if (out_log.size() == 1)
            chk("after_rst_w0", 32'(out_log[0]), 32'h5A1A);

`ifdef TR_FETCH_SUM_EN
        xfer(20'h00020, 20'd2, 0, 0, -1);
        chk("sum_final", 32'(sum), 32'h0001);
`endif

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tr_vector_fetch.md
Name: tr_vector_fetch

Overview:
- Avalon-MM read master on the test-runner side of the SRAM arbiter; drives the arbiter's tr_* slave port.
- On start, reads word_count consecutive SRAM words from base_addr and buffers them in a small FIFO.
- Presents buffered words to the downstream vector driver over a valid/ready stream.
- Absorbs arbiter stalls: tr_waitrequest stays high while the arbiter selects the SOPC master.

Parameters:
- ADDR_WIDTH, 20, SRAM word-address width.
- DATA_WIDTH, 16, SRAM data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- CNT_WIDTH, 20, width of word_count.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; sampled on accepted start.
- word_count  in  CNT_WIDTH  number of words; sampled on accepted start.
- busy  out  1  high in READ and DRAIN.
- done  out  1  one-cycle completion pulse.
- tr_address  out  ADDR_WIDTH  Avalon address (word units).
- tr_byteenable  out  BE_WIDTH  constant all ones.
- tr_read  out  1  Avalon read request.
- tr_readdata  in  DATA_WIDTH  Avalon read data; valid in any cycle with tr_read=1 and tr_waitrequest=0.
- tr_write  out  1  constant 0.
- tr_writedata  out  DATA_WIDTH  constant 0.
- tr_waitrequest  in  1  Avalon stall.
- out_data  out  DATA_WIDTH  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset values: busy=0, done=0, tr_read=0, tr_address=0, out_valid=0, out_data=0, FIFO empty, state IDLE.
- Reset mid-operation: abort the transfer and flush the FIFO on the same edge; tr_read is low from the next cycle. No done pulse.
- IDLE:
  - start=1 with word_count>0 -> latch addr=base_addr and rem=word_count, go to READ.
  - start=1 with word_count=0 -> go to DONE.
- READ:
  - tr_read = (rem!=0) && (registered FIFO occupancy < FIFO_DEPTH). It is a registered-state function only; there is no combinational path from out_ready.
  - tr_address = addr; hold address and read stable while tr_waitrequest=1.
  - Beat completes in a cycle with tr_read && !tr_waitrequest: push tr_readdata into the FIFO, addr <= addr+1 (wraps mod 2^ADDR_WIDTH), rem <= rem-1.
  - Final beat (rem becomes 0) -> DRAIN.
- DRAIN: tr_read=0; when the FIFO is empty -> DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- FIFO:
  - Pop when out_valid && out_ready.
  - A push and a pop in the same cycle are both performed.
  - A FIFO that is full at the start of a cycle issues no read in that cycle, even if a pop occurs.
  - Overflow and underflow are impossible by construction; assert on them in simulation.
- Latency, with no stalls and out_ready=1:
  - start sampled at edge N.
  - tr_read high in cycle N+1.
  - First word out_valid in cycle N+2.
  - Sustained rate is one word per cycle when FIFO_DEPTH>=2.

Optional Feature:
- Macro: TR_FETCH_SUM_EN.
- When defined:
  - Extra output port sum (DATA_WIDTH), reset 0, cleared on accepted start.
  - Adds every word pushed into the FIFO, mod 2^DATA_WIDTH.
  - Final and stable from the done cycle until the next start.
- When undefined: port absent, no adder logic.

Decomposition:
- Package tr_fetch_pkg:
  - State encoding localparams IDLE, READ, DRAIN, DONE.
  - Default FIFO_DEPTH.
  - Shared ADDR_WIDTH and DATA_WIDTH defaults matching the arbiter.
- Sub-module tr_fifo:
  - Synchronous FIFO with push, pop, full, empty and occupancy count.
  - Parameters DATA_WIDTH and FIFO_DEPTH; synchronous active-high reset.

Test Plan:
- Basic read: base_addr=0x00010, word_count=3, SRAM model [0x10]=0xA001, [0x11]=0xA002, [0x12]=0xA003, waitrequest=0, out_ready=1 -> out_data sequence A001, A002, A003; done pulses once; addresses 0x10..0x12.
- Arbiter stall: tr_waitrequest=1 for cycles 2-6 of the transfer -> tr_address and tr_read held stable; no push during the stall; same 3 words delivered.
- Backpressure: word_count=8, out_ready=0 until 10 cycles after start -> exactly 4 reads issued, tr_read low while full; all 8 words delivered in order after release.
- Boundaries:
  - word_count=0 -> no tr_read; done high on the 2nd cycle after start.
  - base_addr=0xFFFFF, word_count=2 -> addresses 0xFFFFF then 0x00000.
- Reset mid-transfer: reset asserted after 2 of 6 words -> tr_read=0 and out_valid=0 next cycle, no done.
  - A subsequent start with word_count=1 works normally.
- TR_FETCH_SUM_EN: words 0xFFFF, 0x0002 -> sum=0x0001 at done.
